// File: rtl/mux41_pkg.sv
// Shared constants and state encoding for the 4:1 mux round-robin feeder.
package mux41_pkg;

   localparam int SELW = 2;
   localparam int NCH  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CAPT = 1'b1
   } state_t;

   function automatic logic [NCH-1:0] ch_onehot(input logic [SELW-1:0] ch);
      logic [NCH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request scanning from last+1 upward, modulo 4.
module rr_pick4
   import mux41_pkg::*;
(
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] last,
   output logic [SELW-1:0] winner,
   output logic            any
);

   logic [SELW-1:0] idx;
   logic            found;

   always_comb begin
      winner = last;
      found  = 1'b0;
      idx    = last;
      for (int i = 1; i <= NCH; i++) begin
         idx = last + SELW'(i);
         if (req[idx] && !found) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/mux41_rr_feeder.sv
// Round-robin feeder for a 4:1 mux: grants a requester, drives sel, captures y and
// presents it downstream as a valid/ready stream tagged with the source channel.
module mux41_rr_feeder
   import mux41_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NCH-1:0]  req,
   output logic [NCH-1:0]  ack,
   output logic [SELW-1:0] sel,
   input  logic [DW-1:0]   y_in,
   output logic [DW-1:0]   out_data,
   output logic [SELW-1:0] out_ch,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy
);

   // Downstream handshake: a word transfers on a rising edge where out_valid & out_ready;
   // out_data/out_ch hold steady while out_valid & !out_ready.
   state_t          state, state_n;
   logic [SELW-1:0] last, sel_n, winner;
   logic            any, load, slot_free;

   // A channel being acked this cycle is excluded so its held req is not granted twice.
   rr_pick4 u_pick (
      .req    (req & ~ack),
      .last   (last),
      .winner (winner),
      .any    (any)
   );

   assign slot_free = !out_valid || out_ready;
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_n = state;
      sel_n   = sel;
      load    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any) begin
               sel_n   = winner;
               state_n = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (slot_free) begin
               load    = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sel       <= '0;
         last      <= SELW'(NCH - 1);
         ack       <= '0;
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         ack   <= load ? ch_onehot(sel) : '0;
         if (load) begin
            out_data  <= y_in;
            out_ch    <= sel;
            out_valid <= 1'b1;
            last      <= sel;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux41_rr_feeder.sv
// Directed bench for mux41_rr_feeder: table-driven fairness run plus hand sequences for
// single grant, back-pressure, wrap-around, idle and asynchronous reset.
module tb_mux41_rr_feeder;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [3:0]    ack;
   logic [1:0]    sel;
   logic [DW-1:0] y_in;
   logic [DW-1:0] out_data;
   logic [1:0]    out_ch;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic [DW-1:0] mux_in [4];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0]    req;
      logic          ready;
      logic [1:0]    sel;
      logic [3:0]    ack;
      logic          valid;
      logic [DW-1:0] data;
      logic [1:0]    ch;
      logic          busy;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   // Behavioural 4:1 mux the feeder drives.
   assign y_in = mux_in[sel];

   mux41_rr_feeder #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .ack       (ack),
      .sel       (sel),
      .y_in      (y_in),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] e_sel, input logic [3:0] e_ack,
                            input logic e_valid, input logic [DW-1:0] e_data,
                            input logic [1:0] e_ch, input logic e_busy);
      check({tag, ".sel"},   32'(sel),       32'(e_sel));
      check({tag, ".ack"},   32'(ack),       32'(e_ack));
      check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
      check({tag, ".data"},  32'(out_data),  32'(e_data));
      check({tag, ".ch"},    32'(out_ch),    32'(e_ch));
      check({tag, ".busy"},  32'(busy),      32'(e_busy));
   endtask

   initial begin
      logic [1:0] held_sel;

      //               req     rdy   sel    ack     vld   data   ch     busy
      vecs[0]  = '{4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b1};
      vecs[1]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0};
      vecs[2]  = '{4'b1111, 1'b1, 2'd1, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b1};
      vecs[3]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 4'h2, 2'd1, 1'b0};
      vecs[4]  = '{4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 4'h2, 2'd1, 1'b1};
      vecs[5]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 4'h3, 2'd2, 1'b0};
      vecs[6]  = '{4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 4'h3, 2'd2, 1'b1};
      vecs[7]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0};
      vecs[8]  = '{4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 4'h4, 2'd3, 1'b1};
      vecs[9]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0};
      vecs[10] = '{4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b0};

      mux_in[0] = 4'h1; mux_in[1] = 4'h2; mux_in[2] = 4'h3; mux_in[3] = 4'h4;
      rst_n = 1'b0; req = '0; out_ready = 1'b0;
      step();
      step();
      check_all("reset", 2'd0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
      rst_n = 1'b1;

      // Fairness: all four held, channels served 0,1,2,3,0 one word per 2 cycles.
      for (int i = 0; i < 11; i++) begin
         req       = vecs[i].req;
         out_ready = vecs[i].ready;
         step();
         check_all($sformatf("fair[%0d]", i), vecs[i].sel, vecs[i].ack, vecs[i].valid,
                   vecs[i].data, vecs[i].ch, vecs[i].busy);
      end

      // Single request on ch2 with c=A.
      mux_in[2] = 4'hA;
      req = 4'b0100;
      step();
      check_all("single.grant", 2'd2, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b1);
      step();
      check_all("single.capt", 2'd2, 4'b0100, 1'b1, 4'hA, 2'd2, 1'b0);
      req = 4'b0000;
      step();
      check_all("single.pop", 2'd2, 4'b0000, 1'b0, 4'hA, 2'd2, 1'b0);

      // Back-pressure: word from ch3 pending, ch0 must stall in CAPT until out_ready.
      out_ready = 1'b0;
      req = 4'b1000;
      step();
      step();
      check_all("bp.first", 2'd3, 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0);
      req = 4'b0001;
      step();
      check_all("bp.grant", 2'd0, 4'b0000, 1'b1, 4'h4, 2'd3, 1'b1);
      step();
      check_all("bp.stall1", 2'd0, 4'b0000, 1'b1, 4'h4, 2'd3, 1'b1);
      step();
      check_all("bp.stall2", 2'd0, 4'b0000, 1'b1, 4'h4, 2'd3, 1'b1);
      out_ready = 1'b1;
      step();
      check_all("bp.swap", 2'd0, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0);
      req = 4'b0000;
      step();
      check_all("bp.drain", 2'd0, 4'b0000, 1'b0, 4'h1, 2'd0, 1'b0);

      // Wrap: serve ch3 (last=3), then 1001 -> ch0, then 1001 -> ch3.
      req = 4'b1000;
      step();
      step();
      check_all("wrap.pre", 2'd3, 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0);
      req = 4'b1001;
      step();
      check("wrap.sel0", 32'(sel), 32'd0);
      step();
      check_all("wrap.capt0", 2'd0, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0);
      step();
      check("wrap.sel3", 32'(sel), 32'd3);
      out_ready = 1'b0;
      step();
      check_all("wrap.capt3", 2'd3, 4'b1000, 1'b1, 4'h4, 2'd3, 1'b0);

      // Idle: no requests, a word left pending downstream must stay put.
      req = 4'b0000;
      held_sel = sel;
      for (int i = 0; i < 20; i++) begin
         step();
         check_all($sformatf("idle[%0d]", i), held_sel, 4'b0000, 1'b1, 4'h4, 2'd3, 1'b0);
      end

      // Asynchronous reset in the middle of a capture.
      out_ready = 1'b1;
      req = 4'b0010;
      step();
      check_all("rst.capt", 2'd1, 4'b0000, 1'b0, 4'h4, 2'd3, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst.async", 2'd0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("rst.after[%0d]", i), 2'd0, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
